mutative_dfp_arbiter: RTL and testbench
=======================================

// Module: mutative_dfp_arbiter
// PURPOSE
// Shares one 256-bit line-granular memory port (dfp) between two cache instances, requester 0 (I-side) and requester 1 (D-side).
// Sits between the two caches' dfp ports and the memory model / next level.
// Grants one whole transaction at a time with round-robin fairness and registered downstream outputs.
// Provides a one-cycle turnaround after each response so a requester never issues the same transaction twice.
// PARAMETERS
// ADDR_W  32   address width, line-aligned, passed through unmodified
// LINE_W  256  line data width
// PORTS
// clk          in   1       clock
// rst          in   1       synchronous reset, active-low (rst==0 resets)
// ufp0_addr    in   ADDR_W  requester 0 line address
// ufp0_read    in   1       requester 0 line read request
// ufp0_write   in   1       requester 0 line write (writeback) request
// ufp0_wdata   in   LINE_W  requester 0 writeback data
// ufp0_rdata   out  LINE_W  read data to requester 0 (= dfp_rdata)
// ufp0_resp    out  1       transaction-complete pulse to requester 0
// ufp1_*       same set as ufp0_*, for requester 1
// dfp_addr     out  ADDR_W  memory address
// dfp_read     out  1       memory read
// dfp_write    out  1       memory write
// dfp_wdata    out  LINE_W  memory write data
// dfp_rdata    in   LINE_W  memory read data
// dfp_resp     in   1       memory response, 1-cycle pulse
// owner        out  1       requester owning current/last transaction
// busy         out  1       state != IDLE
// proto_err    out  1       sticky: some ufpN_read && ufpN_write seen in IDLE
// BEHAVIOUR
// - Reset: state=IDLE; dfp_addr/read/write/wdata=0; owner=0; proto_err=0; rr_last=1, so requester 0 wins the first tie.
// - States: IDLE -> ISSUE -> TURN -> IDLE.
// - IDLE: reqN = ufpN_read|ufpN_write.
//   - Only one reqN set: grant N.
//   - Both set: grant the requester != rr_last.
//   - On grant: latch addr, wdata and read/write into the dfp registers; owner<=N; rr_last<=N; go ISSUE.
//   - Result: dfp_read/dfp_write assert exactly 1 cycle after the request is seen.
// - ISSUE: dfp outputs held constant from the latched values; ufp inputs ignored.
//   - On dfp_resp: ufp<owner>_resp=1 combinationally in the same cycle; the other ufp resp stays 0.
//   - Next cycle: dfp_read/write/addr/wdata cleared to 0; go TURN.
// - TURN: exactly one cycle; no arbitration, no dfp activity; next state IDLE.
// - ufpN_rdata = dfp_rdata always. Data is only valid in the cycle where ufpN_resp=1.
// - Simultaneous read & write from one requester:
//   - Treated as a write (writeback first).
//   - proto_err<=1, cleared only by reset.
// - Requester drops its request during ISSUE: the transaction still completes using latched values, and resp is still pulsed.
// - dfp_resp outside ISSUE: ignored; no ufp resp is generated.
// - Request that arrives in ISSUE/TURN: not lost; it is arbitrated in the next IDLE, provided the requester holds it (caches hold until resp).
// - Fairness bound: under continuous requests from both sides, grants alternate 0,1,0,1...
//   - A waiting requester waits at most one full transaction plus 2 cycles.
// - Reset asserted mid-transaction: all outputs return to reset values next cycle; the pending resp is never delivered.
// - busy = (state!=IDLE); owner holds its value in IDLE.
// - No combinational path from ufp inputs to dfp outputs.
// - The only combinational input->output paths: dfp_resp -> ufpN_resp, and dfp_rdata -> ufpN_rdata.
// TESTING
// - Single read:
//   - Stimulus: ufp0_read=1, ufp0_addr=0x0000_1240; memory responds 3 cycles later with rdata=0xA5..A5.
//   - Required: dfp_read=1 and dfp_addr=0x1240 from cycle+1; ufp0_resp=1 with rdata=0xA5..A5 in the resp cycle; ufp1_resp=0 throughout; busy returns to 0 after TURN.
// - Tie after reset:
//   - Stimulus: ufp0_read and ufp1_write (addr 0x2000, wdata 0x1234..) asserted in the same cycle.
//   - Required: requester 0 is served first; then requester 1 gets dfp_write=1, dfp_addr=0x2000 and the matching wdata; owner sequence is 0,1.
// - Continuous contention: both requesters re-request immediately after each resp for 8 transactions -> owner sequence is 0,1,0,1,0,1,0,1 and each requester gets exactly 4 resp pulses.
// - Early drop: ufp1 drops write in ISSUE -> dfp_write stays 1 until resp; ufp1_resp still pulses once.
// - Protocol error:
//   - Stimulus: ufp0_read=1 and ufp0_write=1 together.
//   - Required: dfp_write=1 (not dfp_read); proto_err=1 and it stays 1 until rst=0.
// - Reset mid-op: rst=0 for 1 cycle during ISSUE -> next cycle dfp_read=dfp_write=0, busy=0, no ufp resp; a spurious dfp_resp afterward is ignored.

Source files
------------

// File: rtl/mutative_dfp_arbiter.sv
// mutative_dfp_arbiter
//   Shares one line-granular memory port (dfp) between two caches:
//   requester 0 (I-side) and requester 1 (D-side). One whole transaction is
//   granted at a time. Arbitration is round-robin, and the downstream outputs
//   are registered. A one-cycle turnaround follows every response so that a
//   requester never issues the same transaction twice.
//
// Ports
//   clk, rst                 clock; synchronous active-low reset
//   ufpN_addr/read/write     requester N line request (N = 0, 1)
//   ufpN_wdata               requester N writeback data
//   ufpN_rdata               read data to requester N (always dfp_rdata)
//   ufpN_resp                transaction-complete pulse to requester N
//   dfp_addr/read/write      registered memory request
//   dfp_wdata                registered memory write data
//   dfp_rdata, dfp_resp      memory read data and 1-cycle response
//   owner                    requester owning the current/last transaction
//   busy                     high whenever the arbiter is not idle
//   proto_err                sticky flag: read and write seen together in IDLE
module mutative_dfp_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ufp0_addr,
  input  logic              ufp0_read,
  input  logic              ufp0_write,
  input  logic [LINE_W-1:0] ufp0_wdata,
  output logic [LINE_W-1:0] ufp0_rdata,
  output logic              ufp0_resp,
  input  logic [ADDR_W-1:0] ufp1_addr,
  input  logic              ufp1_read,
  input  logic              ufp1_write,
  input  logic [LINE_W-1:0] ufp1_wdata,
  output logic [LINE_W-1:0] ufp1_rdata,
  output logic              ufp1_resp,
  output logic [ADDR_W-1:0] dfp_addr,
  output logic              dfp_read,
  output logic              dfp_write,
  output logic [LINE_W-1:0] dfp_wdata,
  input  logic [LINE_W-1:0] dfp_rdata,
  input  logic              dfp_resp,
  output logic              owner,
  output logic              busy,
  output logic              proto_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, TURN} state_t;

  state_t state, state_next;
  logic   rr_last;
  logic   req0, req1;
  logic   grant_valid, grant_id;
  logic   sel_read, sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [LINE_W-1:0] sel_wdata;

  assign ufp0_rdata = dfp_rdata;
  assign ufp1_rdata = dfp_rdata;
  assign busy       = (state != IDLE);

  always_comb begin
    state_next  = state;
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    req0        = ufp0_read | ufp0_write;
    req1        = ufp1_read | ufp1_write;
    unique case (state)
      IDLE: begin
        if (req0 && req1) begin
          grant_valid = 1'b1;
          grant_id    = ~rr_last;
        end else if (req0) begin
          grant_valid = 1'b1;
          grant_id    = 1'b0;
        end else if (req1) begin
          grant_valid = 1'b1;
          grant_id    = 1'b1;
        end
        if (grant_valid) state_next = ISSUE;
      end
      ISSUE:   if (dfp_resp) state_next = TURN;
      TURN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Selected requester's fields, used only when a grant is taken.
  always_comb begin
    sel_read  = grant_id ? ufp1_read  : ufp0_read;
    sel_write = grant_id ? ufp1_write : ufp0_write;
    sel_addr  = grant_id ? ufp1_addr  : ufp0_addr;
    sel_wdata = grant_id ? ufp1_wdata : ufp0_wdata;
  end

  // Response is only routed while a transaction is outstanding; the rst term
  // keeps a response coinciding with reset from reaching a requester.
  always_comb begin
    ufp0_resp = 1'b0;
    ufp1_resp = 1'b0;
    if (state == ISSUE && dfp_resp && rst) begin
      ufp0_resp = ~owner;
      ufp1_resp = owner;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      dfp_addr  <= '0;
      dfp_read  <= 1'b0;
      dfp_write <= 1'b0;
      dfp_wdata <= '0;
      owner     <= 1'b0;
      rr_last   <= 1'b1;
      proto_err <= 1'b0;
    end else begin
      state <= state_next;
      if (grant_valid) begin
        dfp_addr  <= sel_addr;
        dfp_wdata <= sel_wdata;
        // Read+write together is served as a writeback.
        dfp_write <= sel_write;
        dfp_read  <= sel_read & ~sel_write;
        owner     <= grant_id;
        rr_last   <= grant_id;
      end
      if (state == ISSUE && dfp_resp) begin
        dfp_addr  <= '0;
        dfp_read  <= 1'b0;
        dfp_write <= 1'b0;
        dfp_wdata <= '0;
      end
      if (state == IDLE && ((ufp0_read && ufp0_write) || (ufp1_read && ufp1_write)))
        proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mutative_dfp_arbiter.sv
module tb_mutative_dfp_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  ufp0_addr, ufp1_addr, dfp_addr;
  logic         ufp0_read, ufp0_write, ufp1_read, ufp1_write;
  logic [255:0] ufp0_wdata, ufp1_wdata, ufp0_rdata, ufp1_rdata;
  logic         ufp0_resp, ufp1_resp;
  logic         dfp_read, dfp_write, dfp_resp;
  logic [255:0] dfp_wdata, dfp_rdata;
  logic         owner, busy, proto_err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  mutative_dfp_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
    .clk(clk), .rst(rst),
    .ufp0_addr(ufp0_addr), .ufp0_read(ufp0_read), .ufp0_write(ufp0_write),
    .ufp0_wdata(ufp0_wdata), .ufp0_rdata(ufp0_rdata), .ufp0_resp(ufp0_resp),
    .ufp1_addr(ufp1_addr), .ufp1_read(ufp1_read), .ufp1_write(ufp1_write),
    .ufp1_wdata(ufp1_wdata), .ufp1_rdata(ufp1_rdata), .ufp1_resp(ufp1_resp),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .owner(owner), .busy(busy), .proto_err(proto_err)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after
  // the edge. The memory response is a single-cycle pulse, so drop it here.
  task automatic tick();
    @(posedge clk);
    #1;
    dfp_resp = 1'b0;
  endtask

  task automatic pulse_resp(input logic [255:0] data);
    dfp_rdata = data;
    dfp_resp  = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  logic [255:0] pat_a5, pat_1234, pat_beef;
  int unsigned  cnt0, cnt1, waited;

  initial begin
    pat_a5   = {32{8'hA5}};
    pat_1234 = {8{32'h12345678}};
    pat_beef = {8{32'hDEADBEEF}};
    rst = 1'b0;
    ufp0_addr = '0; ufp0_read = 1'b0; ufp0_write = 1'b0; ufp0_wdata = '0;
    ufp1_addr = '0; ufp1_read = 1'b0; ufp1_write = 1'b0; ufp1_wdata = '0;
    dfp_rdata = '0; dfp_resp = 1'b0;
    #1;
    do_reset();

    check("rst_dfp_read", dfp_read, 0);
    check("rst_dfp_write", dfp_write, 0);
    check("rst_dfp_addr", dfp_addr, 0);
    check("rst_owner", owner, 0);
    check("rst_busy", busy, 0);
    check("rst_proto_err", proto_err, 0);

    // Single read, memory answers 3 cycles after the request is issued.
    ufp0_read = 1'b1; ufp0_addr = 32'h0000_1240;
    tick();
    check("rd_dfp_read", dfp_read, 1);
    check("rd_dfp_addr", dfp_addr, 32'h1240);
    check("rd_busy", busy, 1);
    tick();
    check("rd_hold_read", dfp_read, 1);
    check("rd_no_resp0", ufp0_resp, 0);
    tick();
    pulse_resp(pat_a5);
    check("rd_resp0", ufp0_resp, 1);
    check("rd_rdata0", ufp0_rdata, pat_a5);
    check("rd_resp1", ufp1_resp, 0);
    ufp0_read = 1'b0;
    tick();
    check("rd_turn_read", dfp_read, 0);
    check("rd_turn_busy", busy, 1);
    check("rd_turn_resp0", ufp0_resp, 0);
    tick();
    check("rd_idle_busy", busy, 0);

    // Tie after reset: requester 0 first, then requester 1's write.
    do_reset();
    ufp0_read = 1'b1; ufp0_addr = 32'h3000;
    ufp1_write = 1'b1; ufp1_addr = 32'h2000; ufp1_wdata = pat_1234;
    tick();
    check("tie_owner0", owner, 0);
    check("tie_read0", dfp_read, 1);
    check("tie_addr0", dfp_addr, 32'h3000);
    pulse_resp(pat_a5);
    check("tie_resp0", ufp0_resp, 1);
    check("tie_noresp1", ufp1_resp, 0);
    ufp0_read = 1'b0;
    tick();
    tick();
    check("tie_idle_gap", busy, 0);
    tick();
    check("tie_owner1", owner, 1);
    check("tie_write1", dfp_write, 1);
    check("tie_noread1", dfp_read, 0);
    check("tie_addr1", dfp_addr, 32'h2000);
    check("tie_wdata1", dfp_wdata, pat_1234);
    pulse_resp('0);
    check("tie_resp1", ufp1_resp, 1);
    check("tie_noresp0", ufp0_resp, 0);
    ufp1_write = 1'b0;
    tick();
    tick();

    // Continuous contention: grants alternate starting with 0.
    ufp0_read = 1'b1; ufp0_addr = 32'h100;
    ufp1_read = 1'b1; ufp1_addr = 32'h200;
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 8; i++) begin
      waited = 0;
      while (!busy && waited < 10) begin
        tick();
        waited++;
      end
      if (!busy) check("cont_timeout", 0, 1);
      check($sformatf("cont_owner%0d", i), owner, (i % 2));
      check($sformatf("cont_addr%0d", i), dfp_addr, (i % 2) ? 32'h200 : 32'h100);
      tick();
      pulse_resp(pat_beef);
      cnt0 += ufp0_resp;
      cnt1 += ufp1_resp;
      tick();
      tick();
    end
    check("cont_cnt0", cnt0, 4);
    check("cont_cnt1", cnt1, 4);
    ufp0_read = 1'b0; ufp1_read = 1'b0;
    tick();
    check("cont_idle", busy, 0);

    // Early drop: requester 1 releases its write during ISSUE.
    ufp1_write = 1'b1; ufp1_addr = 32'h4000; ufp1_wdata = pat_beef;
    tick();
    check("drop_owner", owner, 1);
    ufp1_write = 1'b0;
    tick();
    check("drop_write_held", dfp_write, 1);
    check("drop_addr_held", dfp_addr, 32'h4000);
    tick();
    check("drop_wdata_held", dfp_wdata, pat_beef);
    pulse_resp('0);
    check("drop_resp1", ufp1_resp, 1);
    check("drop_noresp0", ufp0_resp, 0);
    tick();
    check("drop_cleared", dfp_write, 0);
    check("drop_resp1_once", ufp1_resp, 0);
    // Stray response during TURN must not reach anyone.
    pulse_resp('0);
    check("turn_stray_resp0", ufp0_resp, 0);
    check("turn_stray_resp1", ufp1_resp, 0);
    tick();
    check("turn_stray_idle", busy, 0);

    // Protocol error: read+write together is served as a write.
    ufp0_read = 1'b1; ufp0_write = 1'b1; ufp0_addr = 32'h5000; ufp0_wdata = pat_1234;
    tick();
    check("perr_write", dfp_write, 1);
    check("perr_noread", dfp_read, 0);
    check("perr_flag", proto_err, 1);
    pulse_resp('0);
    check("perr_resp0", ufp0_resp, 1);
    ufp0_read = 1'b0; ufp0_write = 1'b0;
    tick();
    tick();
    tick();
    check("perr_sticky", proto_err, 1);

    // Reset during ISSUE.
    ufp0_read = 1'b1; ufp0_addr = 32'h6000;
    tick();
    check("rmid_read", dfp_read, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    ufp0_read = 1'b0;
    check("rmid_read_clr", dfp_read, 0);
    check("rmid_write_clr", dfp_write, 0);
    check("rmid_busy", busy, 0);
    check("rmid_addr", dfp_addr, 0);
    check("rmid_perr_clr", proto_err, 0);
    pulse_resp(pat_a5);
    check("rmid_stray0", ufp0_resp, 0);
    check("rmid_stray1", ufp1_resp, 0);
    tick();
    check("rmid_still_idle", busy, 0);
    check("rmid_no_read", dfp_read, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
